// File: rtl/pdm_rec_play_ctrl.sv
// Record/playback sequencer: PDM mic bits -> packed RAM words, RAM words -> gapless PWM bit stream.
// First pwm_bit one edge after PLAY_PRIME; no backpressure, the RAM is assumed always ready.
module pdm_rec_play_ctrl #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 16
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              rec_req,
    input  logic              play_req,
    input  logic              stop,
    input  logic              mic_data,
    output logic              mic_lr_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              pwm_bit,
    output logic              amp_sd,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   rec_len
);
    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
    localparam logic [BW-1:0] PRE_LAST = BW'(WORD_W - 2);

    typedef enum logic [1:0] {IDLE, REC, PLAY_PRIME, PLAY_RUN} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;
    logic              done_q, done_d;

    logic word_last;
    logic last_word;

    assign word_last = (bit_idx_q == LAST_BIT);
    assign last_word = ({1'b0, rd_addr_q} == (rec_len_q - (ADDR_W+1)'(1)));

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            sreg_q    <= '0;
            rec_len_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            sreg_q    <= sreg_d;
            rec_len_q <= rec_len_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        sreg_d    = sreg_q;
        rec_len_d = rec_len_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                if (rec_req) begin
                    state_d   = REC;
                    wr_addr_d = '0;
                    sreg_d    = '0;
                end else if (play_req && (rec_len_q != '0)) begin
                    state_d = PLAY_PRIME;
                end
            end
            REC: begin
                sreg_d    = {sreg_q[WORD_W-2:0], mic_data};
                bit_idx_d = word_last ? '0 : bit_idx_q + BW'(1);
                if (word_last)
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                // A partial word at stop is dropped; a word completing on the stop edge still counts.
                if (stop || (word_last && (&wr_addr_q))) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    rec_len_d = {1'b0, wr_addr_q} + (ADDR_W+1)'(word_last);
                end
            end
            PLAY_PRIME: begin
                if (stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    // RAM has held address 0 since IDLE, so word 0 is already on mem_rdata.
                    state_d   = PLAY_RUN;
                    sreg_d    = mem_rdata;
                    bit_idx_d = '0;
                    rd_addr_d = '0;
                end
            end
            PLAY_RUN: begin
                sreg_d    = {sreg_q[WORD_W-2:0], 1'b0};
                bit_idx_d = word_last ? '0 : bit_idx_q + BW'(1);
                if (word_last) begin
                    sreg_d    = mem_rdata;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
                if (stop || (word_last && last_word)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        case (state_q)
            REC:      mem_addr = wr_addr_q;
            // Prefetch the next word two bits early to cover the RAM read latency.
            PLAY_RUN: mem_addr = (bit_idx_q >= PRE_LAST) ? rd_addr_q + ADDR_W'(1) : rd_addr_q;
            default:  mem_addr = '0;
        endcase
    end

    assign mem_we     = (state_q == REC) && word_last;
    assign mem_wdata  = mem_we ? {sreg_q[WORD_W-2:0], mic_data} : '0;
    assign pwm_bit    = (state_q == PLAY_RUN) && sreg_q[WORD_W-1];
    assign amp_sd     = (state_q == PLAY_PRIME) || (state_q == PLAY_RUN);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign rec_len    = rec_len_q;
    assign mic_lr_sel = 1'b0;

endmodule

// File: tb/tb_pdm_rec_play_ctrl.sv
// Directed + random record/playback sequences against a word-level reference of the sample RAM.
module tb_pdm_rec_play_ctrl;
    localparam int AW = 4;
    localparam int WW = 16;
    localparam int DEPTH = 1 << AW;

    logic          mclk = 1'b0;
    logic          reset = 1'b1;
    logic          rec_req = 1'b0;
    logic          play_req = 1'b0;
    logic          stop = 1'b0;
    logic          mic_data = 1'b0;
    logic          mic_lr_sel;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata = '0;
    logic          pwm_bit;
    logic          amp_sd;
    logic          busy;
    logic          done;
    logic [AW:0]   rec_len;

    int n_assert = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int ref_len = 0;

    logic [WW-1:0] ram [DEPTH];
    logic [WW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] wq_addr [$];
    logic [WW-1:0] wq_data [$];

    pdm_rec_play_ctrl #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .mclk(mclk), .reset(reset), .rec_req(rec_req), .play_req(play_req),
        .stop(stop), .mic_data(mic_data), .mic_lr_sel(mic_lr_sel),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pwm_bit(pwm_bit), .amp_sd(amp_sd),
        .busy(busy), .done(done), .rec_len(rec_len)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge mclk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // mode 0: alternating 1,0 ; mode 1: constant 1 ; mode 2: random
    task automatic do_record(input int nbits, input bit use_stop, input int mode, input bit with_play);
        logic bits [$];
        logic [WW-1:0] word;
        int dc0;
        int nw;
        for (int i = 0; i < nbits; i++)
            bits.push_back(mode == 0 ? logic'(i % 2 == 0) : mode == 1 ? 1'b1 : logic'($urandom_range(0, 1)));
        wq_addr.delete();
        wq_data.delete();
        dc0 = done_cnt;
        rec_req = 1'b1;
        play_req = with_play;
        tick();
        rec_req = 1'b0;
        play_req = 1'b0;
        chk("rec_busy", busy, 1);
        chk("rec_not_play", amp_sd, 0);
        chk("rec_len_hold", rec_len, ref_len);
        for (int i = 0; i < nbits; i++) begin
            mic_data = bits[i];
            stop = use_stop && (i == nbits - 1);
            tick();
        end
        stop = 1'b0;
        mic_data = 1'b0;
        nw = nbits / WW;
        if (nw > DEPTH) nw = DEPTH;
        ref_len = nw;
        chk("rec_done", done, 1);
        chk("rec_idle", busy, 0);
        chk("rec_len", rec_len, ref_len);
        tick();
        chk("rec_done_pulse", done, 0);
        chk("rec_done_count", done_cnt - dc0, 1);
        chk("rec_nwrites", wq_addr.size(), nw);
        for (int k = 0; k < nw && k < wq_addr.size(); k++) begin
            word = '0;
            for (int j = 0; j < WW; j++)
                if (bits[k*WW + j]) word = word | (WW'(1) << (WW - 1 - j));
            ref_mem[k] = word;
            chk("rec_waddr", wq_addr[k], k);
            chk("rec_wdata", wq_data[k], word);
        end
    endtask

    task automatic do_play(input int nw, input int cut, input bit by_reset);
        int dc0;
        int w;
        int b;
        dc0 = done_cnt;
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        chk("prime_amp", amp_sd, 1);
        chk("prime_pwm", pwm_bit, 0);
        chk("prime_busy", busy, 1);
        chk("prime_addr", mem_addr, 0);
        for (int c = 0; c < nw * WW; c++) begin
            tick();
            w = c / WW;
            b = c % WW;
            chk("play_bit", pwm_bit, ref_mem[w][WW-1-b]);
            chk("play_amp", amp_sd, 1);
            chk("play_addr", mem_addr, (b >= WW - 2) ? ((w + 1) % DEPTH) : w);
            chk("play_no_done", done, 0);
            rec_req = (c == 3);
            if (c == cut) begin
                if (by_reset) reset = 1'b1;
                else stop = 1'b1;
                break;
            end
        end
        tick();
        rec_req = 1'b0;
        stop = 1'b0;
        chk("end_pwm", pwm_bit, 0);
        chk("end_amp", amp_sd, 0);
        chk("end_busy", busy, 0);
        if (by_reset) begin
            reset = 1'b0;
            ref_len = 0;
            chk("rst_done", done, 0);
            chk("rst_rec_len", rec_len, 0);
        end else begin
            chk("end_done", done, 1);
        end
        tick();
        chk("end_done_low", done, 0);
        chk("end_done_count", done_cnt - dc0, by_reset ? 0 : 1);
    endtask

    initial begin
        int dc0;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        // Reset held for two edges
        tick();
        tick();
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pwm", pwm_bit, 0);
        chk("rst_amp", amp_sd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rec_len", rec_len, 0);
        chk("rst_lr_sel", mic_lr_sel, 0);
        reset = 1'b0;
        tick();

        // Alternating bits, stop on the 40th bit: two 0xAAAA words, 8 bits dropped
        do_record(40, 1'b1, 0, 1'b0);

        // Preloaded words, full playback
        ram[0] = 16'hF00F;
        ram[1] = 16'h1234;
        ref_mem[0] = 16'hF00F;
        ref_mem[1] = 16'h1234;
        do_play(2, -1, 1'b0);

        // Constant-1 capture fills all 16 words and auto-stops
        do_record(DEPTH * WW, 1'b0, 1, 1'b0);

        // Random capture stopped exactly on a word boundary, then played back
        do_record(3 * WW, 1'b1, 2, 1'b0);
        do_play(3, -1, 1'b0);

        // Stop mid-playback, then reset mid-playback at word 1 bit 5
        do_play(3, 7, 1'b0);
        do_play(3, WW + 5, 1'b1);

        // rec_len is 0: play_req alone is ignored
        dc0 = done_cnt;
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        chk("ign_play_busy", busy, 0);
        chk("ign_play_amp", amp_sd, 0);
        tick();
        chk("ign_play_idle", busy, 0);
        chk("ign_play_done", done_cnt - dc0, 0);

        // rec_req wins over play_req
        do_record(20, 1'b1, 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
